// File: rtl/mod_counter_pkg.sv
// ============================================================================
// Module      : mod_counter_pkg
// Description : Shared limits and direction constants for the modulo counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_pkg;

   // Parameter legality limits
   localparam int MAX_WIDTH   = 16;
   localparam int MIN_MODULUS = 2;

   // Direction encoding of the up input
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage : mod_counter_pkg

`default_nettype wire

// File: rtl/mod_counter_bin2gray.sv
// ============================================================================
// Module      : bin2gray
// Description : Pure combinational WIDTH-bit binary to reflected Gray encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2gray
   import mod_counter_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   // Each Gray bit is the XOR of adjacent binary bits
   assign gray = bin ^ (bin >> 1);

endmodule : bin2gray

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Synchronous up/down modulo counter with enable, clamped
//               parallel load, combinational terminal count and a registered
//               wrap pulse. Defining MOD_COUNTER_GRAY_EN adds a registered
//               Gray-coded copy of the count (count_gray).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             terminal,
   output logic             wrap
`ifdef MOD_COUNTER_GRAY_EN
   ,
   output logic [WIDTH-1:0] count_gray
`endif
);

   // Reject illegal configurations at elaboration time
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("mod_counter: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
   end
   if (MODULUS < MIN_MODULUS || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS=%0d outside %0d..2^WIDTH", MODULUS, MIN_MODULUS);
   end

   // Highest count value; for MODULUS == 2^WIDTH this is all ones, so the
   // explicit compare and natural overflow agree.
   localparam logic [WIDTH-1:0] c_max_count = WIDTH'(MODULUS - 1);
   // Modulus held one bit wider so 2^WIDTH is representable for the clamp
   localparam logic [WIDTH:0]   c_modulus_ext = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             at_max;
   logic             at_zero;
   logic             load_in_range;
   logic             terminal_w;

   // Next-count selection: load (clamped) beats enable, otherwise hold
   always_comb begin
      at_max        = (count_q == c_max_count);
      at_zero       = (count_q == '0);
      load_in_range = ({1'b0, load_value} < c_modulus_ext);
      terminal_w    = enable & ~load &
                      (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));
      wrap_d        = terminal_w;
      count_d       = count_q;
      if (load) begin
         count_d = load_in_range ? load_value : c_max_count;
      end else if (enable) begin
         if (up == DIR_UP) begin
            count_d = at_max ? '0 : (count_q + c_one);
         end else begin
            count_d = at_zero ? c_max_count : (count_q - c_one);
         end
      end
   end

   // Count register and wrap flag; reset aborts any pending wrap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count    = count_q;
   assign terminal = terminal_w;
   assign wrap     = wrap_q;

`ifdef MOD_COUNTER_GRAY_EN
   logic [WIDTH-1:0] count_gray_q;
   logic [WIDTH-1:0] count_gray_d;

   // Encode the next count so the Gray register updates on the same edge
   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin  (count_d),
      .gray (count_gray_d)
   );

   // Gray register, aligned with count_q
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_gray_q <= '0;
      end else begin
         count_gray_q <= count_gray_d;
      end
   end

   assign count_gray = count_gray_q;
`endif

endmodule : mod_counter

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// Module      : tb_mod_counter
// Description : Self-checking bench for mod_counter. Instance A is
//               WIDTH=3/MODULUS=8, instance B is WIDTH=4/MODULUS=10.
//               Gray checks are compiled in with MOD_COUNTER_GRAY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

   typedef struct {
      bit         sel;        // 0 = instance A, 1 = instance B
      bit         en;
      bit         up;
      bit         ld;
      logic [3:0] lv;
      logic [3:0] exp_count;
      bit         exp_wrap;
      bit         exp_term;
      bit         chk_gray;
      logic [2:0] exp_gray;
      string      name;
   } vec_t;

   typedef struct {
      bit         sel;
      logic [3:0] cnt;
      bit         wrap;
      bit         chk_gray;
      logic [2:0] gray;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_en = 1'b0, a_up = 1'b1, a_ld = 1'b0;
   logic [2:0] a_lv = '0;
   logic [2:0] a_cnt;
   logic       a_term, a_wrap;
   logic       b_en = 1'b0, b_up = 1'b1, b_ld = 1'b0;
   logic [3:0] b_lv = '0;
   logic [3:0] b_cnt;
   logic       b_term, b_wrap;
`ifdef MOD_COUNTER_GRAY_EN
   logic [2:0] a_gray;
   logic [3:0] b_gray;
`endif

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(3), .MODULUS(8)) dut_a (
      .clock      (clk),
      .reset_n    (rst_n),
      .enable     (a_en),
      .up         (a_up),
      .load       (a_ld),
      .load_value (a_lv),
      .count      (a_cnt),
      .terminal   (a_term),
      .wrap       (a_wrap)
`ifdef MOD_COUNTER_GRAY_EN
      ,
      .count_gray (a_gray)
`endif
   );

   mod_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
      .clock      (clk),
      .reset_n    (rst_n),
      .enable     (b_en),
      .up         (b_up),
      .load       (b_ld),
      .load_value (b_lv),
      .count      (b_cnt),
      .terminal   (b_term),
      .wrap       (b_wrap)
`ifdef MOD_COUNTER_GRAY_EN
      ,
      .count_gray (b_gray)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic add(input bit sel, input bit en, input bit up, input bit ld,
                      input logic [3:0] lv, input logic [3:0] cnt, input bit wr,
                      input bit term, input string name);
      vec_t v;
      v.sel = sel; v.en = en; v.up = up; v.ld = ld; v.lv = lv;
      v.exp_count = cnt; v.exp_wrap = wr; v.exp_term = term;
      v.chk_gray = 1'b0; v.exp_gray = '0; v.name = name;
      vecs.push_back(v);
   endtask

   // Pops the oldest expectation and compares it with the settled outputs
   task automatic compare_head();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      if (e.sel) begin
         check({e.name, " count"}, b_cnt, e.cnt);
         check({e.name, " wrap"}, b_wrap, e.wrap);
      end else begin
         check({e.name, " count"}, a_cnt, e.cnt);
         check({e.name, " wrap"}, a_wrap, e.wrap);
      end
`ifdef MOD_COUNTER_GRAY_EN
      if (e.chk_gray) check({e.name, " gray"}, a_gray, e.gray);
`endif
   endtask

   // Drive one vector mid-cycle, check terminal before the edge, then
   // check the registered result just after the edge
   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clk);
      if (v.sel) begin
         b_en = v.en; b_up = v.up; b_ld = v.ld; b_lv = v.lv;
         a_en = 1'b0; a_ld = 1'b0;
      end else begin
         a_en = v.en; a_up = v.up; a_ld = v.ld; a_lv = v.lv[2:0];
         b_en = 1'b0; b_ld = 1'b0;
      end
      #1;
      check({v.name, " terminal"}, v.sel ? b_term : a_term, v.exp_term);
      e.sel = v.sel; e.cnt = v.exp_count; e.wrap = v.exp_wrap;
      e.chk_gray = v.chk_gray; e.gray = v.exp_gray; e.name = v.name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_head();
   endtask

   initial begin
      // Watchdog: the sequence is fixed-length, this only guards a stall
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---- Vector table ----
      // A: count up from reset for 10 edges, wrap after the 8th
      for (int k = 1; k <= 10; k++)
         add(0, 1, 1, 0, 0, 4'(k % 8), k == 8, (k - 1) == 7, "a_up");
      // A: count down 2,1,0,7,6 (power-of-two modulus down wrap)
      add(0, 1, 0, 0, 0, 4'd1, 0, 0, "a_down");
      add(0, 1, 0, 0, 0, 4'd0, 0, 0, "a_down");
      add(0, 1, 0, 0, 0, 4'd7, 1, 1, "a_down_wrap");
      add(0, 1, 0, 0, 0, 4'd6, 0, 0, "a_down");
      // B: load 2 then down 1,0,9,8
      add(1, 0, 0, 1, 4'd2, 4'd2, 0, 0, "b_load2");
      add(1, 1, 0, 0, 0, 4'd1, 0, 0, "b_down");
      add(1, 1, 0, 0, 0, 4'd0, 0, 0, "b_down");
      add(1, 1, 0, 0, 0, 4'd9, 1, 1, "b_down_wrap");
      add(1, 1, 0, 0, 0, 4'd8, 0, 0, "b_down");
      // B: out-of-range load clamps; load beats enable at terminal count
      add(1, 1, 1, 1, 4'd13, 4'd9, 0, 0, "b_clamp");
      add(1, 1, 1, 1, 4'd5, 4'd5, 0, 0, "b_load_over_term");
      // B: load 4, hold 3 edges, then flip direction every edge
      add(1, 0, 1, 1, 4'd4, 4'd4, 0, 0, "b_load4");
      for (int k = 0; k < 3; k++)
         add(1, 0, 1, 0, 0, 4'd4, 0, 0, "b_hold");
      add(1, 1, 1, 0, 0, 4'd5, 0, 0, "b_flip");
      add(1, 1, 0, 0, 0, 4'd4, 0, 0, "b_flip");
      add(1, 1, 1, 0, 0, 4'd5, 0, 0, "b_flip");
      add(1, 1, 0, 0, 0, 4'd4, 0, 0, "b_flip");
      // B: up wrap at 9, then enable low drops wrap
      add(1, 0, 1, 1, 4'd9, 4'd9, 0, 0, "b_load9");
      add(1, 1, 1, 0, 0, 4'd0, 1, 1, "b_up_wrap");
      add(1, 0, 1, 0, 0, 4'd0, 0, 0, "b_wrap_drop");
      add(1, 0, 1, 1, 4'd9, 4'd9, 0, 0, "b_reload9");

      // ---- Reset state ----
      #2;
      check("rst_a_count", a_cnt, 0);
      check("rst_a_wrap", a_wrap, 0);
      check("rst_b_count", b_cnt, 0);
      check("rst_b_wrap", b_wrap, 0);
`ifdef MOD_COUNTER_GRAY_EN
      check("rst_a_gray", a_gray, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // ---- Asynchronous reset mid-count (A at 6, B about to wrap) ----
      @(negedge clk);
      a_en = 1'b1; a_up = 1'b1; a_ld = 1'b0;
      b_en = 1'b1; b_up = 1'b1; b_ld = 1'b0;
      #1;
      check("pre_rst_b_terminal", b_term, 1);
      check("pre_rst_a_count", a_cnt, 6);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a_count", a_cnt, 0);
      check("async_rst_a_wrap", a_wrap, 0);
      check("async_rst_b_count", b_cnt, 0);
      @(posedge clk);
      #1;
      check("held_rst_a_count", a_cnt, 0);
      check("held_rst_b_wrap", b_wrap, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("resume_a_count", a_cnt, 1);
      check("resume_b_count", b_cnt, 1);
      check("resume_b_wrap", b_wrap, 0);
      @(negedge clk);
      a_en = 1'b0; b_en = 1'b0;

`ifdef MOD_COUNTER_GRAY_EN
      // ---- Gray sequence over a full up cycle of A ----
      begin
         logic [2:0] gray_seq [0:8];
         logic [2:0] prev;
         vec_t       v;
         gray_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                      3'b111, 3'b101, 3'b100, 3'b000};
         rst_n = 1'b0;
         #1;
         check("gray_rst", a_gray, 0);
         @(negedge clk);
         rst_n = 1'b1;
         prev = gray_seq[0];
         for (int k = 1; k <= 8; k++) begin
            v.sel = 0; v.en = 1; v.up = 1; v.ld = 0; v.lv = '0;
            v.exp_count = 4'(k % 8); v.exp_wrap = (k == 8); v.exp_term = (k == 8);
            v.chk_gray = 1'b1; v.exp_gray = gray_seq[k]; v.name = "gray_step";
            apply(v);
            check("gray_hamming", $countones(a_gray ^ prev), 1);
            prev = a_gray;
         end
      end
`endif

      if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mod_counter

`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Synchronous, parametrised up/down modulo counter. It replaces the chained-flip-flop ripple counter with a single-clock design whose bits all change on the same edge, so no output ever passes through an intermediate value. It adds direction control, enable, parallel load, an arbitrary modulus, a terminal-count indication and a wrap pulse. It is the standard counting element for the sequential examples and for timers/dividers built on top of them.

## Interface
Parameters:
- WIDTH, 3, counter width in bits; legal range 1..16.
- MODULUS, 8, count sequence is 0..MODULUS-1; legal range 2..2^WIDTH. Elaboration fails outside this range.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  count enable; when low, count holds.
- up  input  1  direction; 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value applied when load is high.
- count  output  WIDTH  current count, registered.
- terminal  output  1  combinational; high when the next enabled step will wrap.
- wrap  output  1  registered one-cycle pulse following a wrap.
- count_gray  output  WIDTH  Gray-coded count; present only with MOD_COUNTER_GRAY_EN.

## Operation
- Priority at each rising edge is reset_n low, then load, then enable, then hold.
- Load:
  - count <= load_value if load_value < MODULUS.
  - Otherwise count <= MODULUS-1 (clamp).
  - Load never asserts wrap.
- Enable with up=1: count <= count+1, or 0 when count == MODULUS-1.
- Enable with up=0: count <= count-1, or MODULUS-1 when count == 0.
- terminal = enable & ~load & ((up & count==MODULUS-1) | (~up & count==0)).
- wrap <= terminal on every edge, so it is high for exactly one cycle after each wrap.
- Direction may change on any cycle. The new direction applies at the next edge, with no dead cycle.
- enable low:
  - count and count_gray hold.
  - wrap goes 0 on the next edge.
- Arithmetic is done at WIDTH bits. With MODULUS == 2^WIDTH, natural overflow is the wrap and the compare logic gives the same result.
- No state machine beyond the count register and the wrap flag.

## Timing
- Reset (reset_n low, asynchronous, effective immediately): count = 0, wrap = 0, count_gray = 0. Outputs stay there while reset_n is low.
- reset_n is released synchronously by the surrounding design. The first count change happens on the first rising edge with reset_n high and enable or load high.
- Latency:
  - count changes 1 edge after enable or load is sampled.
  - wrap asserts on the same edge as the wrapping count change.
  - terminal follows its inputs combinationally, with no register.
- Reset asserted mid-count aborts the count, with no pending wrap.
- load and enable asserted together: the load wins, and terminal is 0 that cycle.

## Configuration
- MOD_COUNTER_GRAY_EN defined:
  - Adds the count_gray output, registered.
  - count_gray <= next_count ^ (next_count >> 1), so it is aligned with count on the same edge.
  - With MODULUS a power of two, exactly one bit changes per step.
- MOD_COUNTER_GRAY_EN undefined: the port and its register are absent, and the rest of the behaviour is identical.

## Structure
- Shared package mod_counter_pkg holds:
  - the WIDTH/MODULUS legality limits (MAX_WIDTH = 16, MIN_MODULUS = 2);
  - the direction constants DIR_DOWN = 0, DIR_UP = 1.
- One sub-module, bin2gray, a pure combinational WIDTH-bit binary-to-Gray encoder. It is instantiated only under MOD_COUNTER_GRAY_EN.
- Next-count logic, clamp and terminal compare stay inline in mod_counter.

## Test plan
- Reset then count: WIDTH=3, MODULUS=8, enable=1, up=1 for 10 edges -> count 1,2,…,7,0,1,2. terminal is high while count=7. wrap is high only in the cycle where count=0.
- Down count with non-power-of-two modulus: WIDTH=4, MODULUS=10, load 2, then up=0 for 4 edges -> count 1,0,9,8. wrap is high once, at count=9.
- Load priority and clamp: WIDTH=4, MODULUS=10.
  - load=1 with load_value=13 and enable=1 -> count=9 and wrap=0.
  - load_value=5 -> count=5.
- Hold and direction flip:
  - enable=0 for 3 edges at count=4 -> count stays 4 and terminal=0.
  - Then up toggles every edge with enable=1 -> count 5,4,5,4.
- Asynchronous reset mid-operation: reset_n low between edges at count=6 -> count=0 and wrap=0 immediately, with no clock edge needed. Counting resumes from 0, reaching 1 on the first enabled edge after release.
- Gray output (MOD_COUNTER_GRAY_EN, WIDTH=3, MODULUS=8): a full up cycle gives count_gray 000,001,011,010,110,111,101,100,000, with a Hamming distance of 1 on every step.
